// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Combinational lookup on the fetch PC and a one-cycle-latency update from execute.
module branch_target_buffer #(
   parameter  int ENTRIES = 16,
   localparam int IDX_W   = $clog2(ENTRIES)
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] pc,
   output logic        hit,
   output logic [31:0] brb,
   input  logic        upd_valid,
   input  logic [31:0] upd_pc,
   input  logic [31:0] upd_target,
   input  logic        upd_taken,
   input  logic        flush
);

   localparam int TAG_W = 30 - IDX_W;

   logic [ENTRIES-1:0] valid_mem;
   logic [TAG_W-1:0]   tag_mem    [ENTRIES];
   logic [31:0]        target_mem [ENTRIES];
   logic [1:0]         ctr_mem    [ENTRIES];

   logic [IDX_W-1:0] lk_idx;
   logic [TAG_W-1:0] lk_tag;
   logic [IDX_W-1:0] up_idx;
   logic [TAG_W-1:0] up_tag;
   logic             lk_hit;
   logic             up_match;
   logic             unused_low_bits;

   assign lk_idx = pc[IDX_W+1:2];
   assign lk_tag = pc[31:IDX_W+2];
   assign up_idx = upd_pc[IDX_W+1:2];
   assign up_tag = upd_pc[31:IDX_W+2];

   // Byte offset bits never take part in indexing or tag compare.
   assign unused_low_bits = ^{pc[1:0], upd_pc[1:0]};

   assign lk_hit   = valid_mem[lk_idx] && (tag_mem[lk_idx] == lk_tag) && ctr_mem[lk_idx][1];
   assign hit      = lk_hit;
   assign brb      = lk_hit ? target_mem[lk_idx] : 32'd0;
   assign up_match = valid_mem[up_idx] && (tag_mem[up_idx] == up_tag);

   function automatic logic [1:0] ctr_next(input logic [1:0] c, input logic taken);
      logic [1:0] n;
      n = c;
      if (taken && (c != 2'b11)) begin
         n = c + 2'd1;
      end else if (!taken && (c != 2'b00)) begin
         n = c - 2'd1;
      end
      return n;
   endfunction

   // Flush only drops valid bits; it wins over a same-cycle update.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_mem  <= '0;
         tag_mem    <= '{default: '0};
         target_mem <= '{default: '0};
         ctr_mem    <= '{default: '0};
      end else if (flush) begin
         valid_mem <= '0;
      end else if (upd_valid) begin
         if (up_match) begin
            ctr_mem[up_idx] <= ctr_next(ctr_mem[up_idx], upd_taken);
            if (upd_taken) begin
               target_mem[up_idx] <= upd_target;
            end
         end else if (upd_taken) begin
            valid_mem[up_idx]  <= 1'b1;
            tag_mem[up_idx]    <= up_tag;
            target_mem[up_idx] <= upd_target;
            ctr_mem[up_idx]    <= 2'b10;
         end
      end
   end

endmodule

// File: tb/tb_branch_target_buffer.sv
// Scoreboard bench for branch_target_buffer: stimulus queues expected lookups,
// a negedge monitor pops and compares them against hit/brb.
module tb_branch_target_buffer;

   typedef struct packed {
      logic        hit;
      logic [31:0] brb;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic [31:0] pc;
   logic        hit;
   logic [31:0] brb;
   logic        upd_valid;
   logic [31:0] upd_pc;
   logic [31:0] upd_target;
   logic        upd_taken;
   logic        flush;

   logic  chk_req;
   logic  stim_done;
   exp_t  exp_q[$];
   string name_q[$];
   int    checks;
   int    errors;

   branch_target_buffer #(.ENTRIES(16)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .pc         (pc),
      .hit        (hit),
      .brb        (brb),
      .upd_valid  (upd_valid),
      .upd_pc     (upd_pc),
      .upd_target (upd_target),
      .upd_taken  (upd_taken),
      .flush      (flush)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One cycle of stimulus, driven just after the rising edge; the check lands
   // on the following falling edge, before the edge that commits any update.
   task automatic applyStimulus(input logic rst, input logic uv, input logic [31:0] upc,
                                input logic [31:0] utgt, input logic utk, input logic fl,
                                input logic [31:0] lpc, input logic chk, input logic ehit,
                                input logic [31:0] ebrb, input string nm);
      exp_t e;
      @(posedge clk);
      #1;
      rst_n      = rst;
      upd_valid  = uv;
      upd_pc     = upc;
      upd_target = utgt;
      upd_taken  = utk;
      flush      = fl;
      pc         = lpc;
      if (chk) begin
         e.hit = ehit;
         e.brb = ebrb;
         exp_q.push_back(e);
         name_q.push_back(nm);
      end
      chk_req = chk;
   endtask

   task automatic upd(input logic [31:0] a, input logic [31:0] t, input logic tk);
      applyStimulus(1'b1, 1'b1, a, t, tk, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, "");
   endtask

   task automatic look(input logic [31:0] a, input logic h, input logic [31:0] b, input string nm);
      applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, a, 1'b1, h, b, nm);
   endtask

   task automatic checkOutput();
      exp_t  e;
      string nm;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("[TB] FAIL underflow: check requested with empty scoreboard, hit=%0b brb=%h", hit, brb);
      end else begin
         e  = exp_q.pop_front();
         nm = name_q.pop_front();
         if (hit !== e.hit || brb !== e.brb) begin
            errors++;
            $display("[TB] FAIL %s: got hit=%0b brb=%h, expected hit=%0b brb=%h",
                     nm, hit, brb, e.hit, e.brb);
         end
      end
   endtask

   // Monitor: compares whenever a lookup check is pending, and closes the run.
   initial begin
      checks = 0;
      errors = 0;
      forever begin
         @(negedge clk);
         if (chk_req) checkOutput();
         if (stim_done) begin
            if (exp_q.size() != 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL leftover: %0d expected entries never checked, required 0", exp_q.size());
            end
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
         end
      end
   end

   initial begin
      rst_n      = 1'b1;
      pc         = 32'h40;
      upd_valid  = 1'b0;
      upd_pc     = 32'h0;
      upd_target = 32'h0;
      upd_taken  = 1'b0;
      flush      = 1'b0;
      chk_req    = 1'b0;
      stim_done  = 1'b0;
      #1 rst_n = 1'b0;

      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h40, 1'b1, 1'b0, 32'h0, "reset_held");
      look(32'h40, 1'b0, 32'h0, "after_reset");

      upd(32'h40, 32'h100, 1'b1);
      look(32'h40, 1'b1, 32'h100, "alloc_40");
      upd(32'h44, 32'h777, 1'b0);
      look(32'h44, 1'b0, 32'h0, "no_alloc_nt_44");

      look(32'h80, 1'b0, 32'h0, "alias_80_miss");
      upd(32'h80, 32'h200, 1'b1);
      look(32'h80, 1'b1, 32'h200, "alias_80_hit");
      look(32'h40, 1'b0, 32'h0, "alias_40_evicted");

      // Counter hysteresis on a freshly reallocated 0x40 (starts at 10).
      upd(32'h40, 32'h100, 1'b1);
      look(32'h40, 1'b1, 32'h100, "realloc_40");
      upd(32'h40, 32'h0, 1'b0);
      look(32'h40, 1'b0, 32'h0, "hyst_01");
      upd(32'h40, 32'h100, 1'b1);
      look(32'h40, 1'b1, 32'h100, "hyst_10");
      upd(32'h40, 32'h100, 1'b1);
      upd(32'h40, 32'h100, 1'b1);
      upd(32'h40, 32'h0, 1'b0);
      look(32'h40, 1'b1, 32'h100, "hyst_sat_hi");
      upd(32'h40, 32'h0, 1'b0);
      upd(32'h40, 32'h0, 1'b0);
      upd(32'h40, 32'h0, 1'b0);
      upd(32'h40, 32'h100, 1'b1);
      look(32'h40, 1'b0, 32'h0, "hyst_sat_lo");
      upd(32'h40, 32'h100, 1'b1);
      look(32'h40, 1'b1, 32'h100, "hyst_back_10");

      applyStimulus(1'b1, 1'b1, 32'h40, 32'h300, 1'b1, 1'b0, 32'h40, 1'b1, 1'b1, 32'h100, "read_old");
      look(32'h40, 1'b1, 32'h300, "read_new");
      upd(32'h40, 32'h999, 1'b0);
      look(32'h40, 1'b1, 32'h300, "nt_keeps_target");

      upd(32'h3c, 32'h600, 1'b1);
      look(32'h3c, 1'b1, 32'h600, "idx15");
      look(32'h3e, 1'b1, 32'h600, "low_bits_ignored");

      applyStimulus(1'b1, 1'b1, 32'h40, 32'h400, 1'b1, 1'b1, 32'h40, 1'b1, 1'b1, 32'h300, "flush_cycle_old");
      look(32'h40, 1'b0, 32'h0, "flush_40");
      look(32'h3c, 1'b0, 32'h0, "flush_3c");
      upd(32'h40, 32'h500, 1'b1);
      look(32'h40, 1'b1, 32'h500, "alloc_after_flush");

      // Reset lands mid-cycle while 0x40 hits and an update to 0x80 is in flight.
      applyStimulus(1'b0, 1'b1, 32'h80, 32'h200, 1'b1, 1'b0, 32'h40, 1'b1, 1'b0, 32'h0, "async_reset_drop");
      applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h80, 1'b1, 1'b0, 32'h0, "reset_discard_upd");
      look(32'h40, 1'b0, 32'h0, "reset_cleared_40");

      applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, "");
      stim_done = 1'b1;
      repeat (20) @(posedge clk);
      $display("[TB] FAIL timeout: monitor did not close the run, expected summary within 20 cycles");
      $fatal(1, "[TB] timeout");
   end

endmodule

// File: doc/branch_target_buffer.md
# branch_target_buffer

Direct-mapped branch target buffer with 2-bit saturating direction counters, sitting in the fetch stage directly upstream of the next-PC select mux. Each cycle it looks up the current fetch PC and drives `hit`/`brb` to that mux, which steers the next PC to the predicted target. Resolved branch and jump outcomes from the execute stage train the table one cycle later.

## Interface
- `ENTRIES`, 16: number of entries; power of two, 2..256.
- `IDX_W`, $clog2(ENTRIES): index width, derived; not overridden.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `pc`  in  32  fetch-stage PC, looked up combinationally.
- `hit`  out  1  predict taken: entry valid, tag match, counter[1]=1.
- `brb`  out  32  predicted target; 32'd0 whenever `hit`=0.
- `upd_valid`  in  1  execute stage resolved a control-transfer instruction this cycle.
- `upd_pc`  in  32  PC of the resolved instruction.
- `upd_target`  in  32  resolved target address.
- `upd_taken`  in  1  resolved direction (1 = taken).
- `flush`  in  1  synchronous invalidate of all entries.

## Operation
- Address split: index = addr[IDX_W+1:2], tag = addr[31:IDX_W+2]; addr[1:0] ignored.
- Entry state: valid (1), tag (30-IDX_W), target (32), ctr (2).
- Lookup (combinational from `pc` and stored state): `hit` = valid & tag match & ctr[1]; `brb` = target when `hit`, else 0.
- Update on rising edge when `upd_valid`=1, at index of `upd_pc`:
  - Tag match and valid: ctr increments if taken (saturates at 2'b11), decrements if not taken (saturates at 2'b00); target overwritten with `upd_target` only when taken.
  - Miss (invalid or tag mismatch) and taken: allocate/replace: valid=1, tag, target=`upd_target`, ctr=2'b10.
  - Miss and not taken: no change.
- `flush`=1: all valid bits cleared at the edge; takes priority over a same-cycle update (the update is dropped).
- Reset (`rst_n`=0): all valid bits cleared, ctr=2'b00, tag and target=0; `hit`=0 and `brb`=0 immediately, without waiting for a clock edge. Reset asserted mid-operation discards any in-flight update.

## Timing
- Lookup latency 0: `hit`/`brb` are valid in the same cycle as `pc`.
- Update latency 1: a write at edge N is visible to lookups from cycle N onward (after the edge).
- Same cycle, same index for lookup and update: lookup returns the pre-update state (read-old).
- One update per cycle; no backpressure, no handshake. `upd_valid` is sampled only at the edge.
- No combinational path from `upd_*` or `flush` to `hit`/`brb`.

## Test plan
- Reset, then `pc`=0x40 -> `hit`=0, `brb`=0. Assert `rst_n`=0 while an entry hits -> `hit` falls before the next edge.
- Update `upd_pc`=0x40, taken, target 0x100, then `pc`=0x40 -> `hit`=1, `brb`=0x100. Update `upd_pc`=0x44, not taken, then `pc`=0x44 -> `hit`=0 (no allocation).
- Alias check (ENTRIES=16), with 0x40 allocated: `pc`=0x80 (same index 0, tag 2) -> `hit`=0. Taken update at 0x80 with target 0x200 -> 0x80 hits 0x200; 0x40 now misses.
- Hysteresis at 0x40: after allocation ctr=10. Not taken -> 01, `hit`=0. Taken -> 10, `hit`=1. Two more taken -> 11 (saturated). One not taken -> 10, still `hit`=1 with `brb`=0x100.
- Same-cycle case: `pc`=0x40 while a taken update to 0x40 with new target 0x300 -> `brb`=0x100 this cycle, 0x300 next cycle.
- `flush` with a simultaneous taken update at 0x40 -> all lookups miss next cycle, including 0x40.
